hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_pkg.sv | 18 +
 rtl/hazard_ctrl_fwd_sel.sv | 24 ++
 rtl/hazard_ctrl.sv | 146 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings and types for the pipeline hazard controller.
package hazard_pkg;

  // ALU operand source select encodings
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Default EX-stage latency of a multi-cycle multiply/divide (legal 2..15)
  localparam int MUL_LAT_DEFAULT = 4;

  // Hazard FSM states
  typedef enum logic {
    RUN     = 1'b0,
    MULBUSY = 1'b1
  } state_t;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Forwarding select for one ALU operand: MEM result beats WB result,
// and register 0 is never forwarded.
module fwd_sel
  import hazard_pkg::*;
(
  input  logic [4:0] src,
  input  logic       we_mem,
  input  logic [4:0] wa_mem,
  input  logic       we_wb,
  input  logic [4:0] wa_wb,
  output logic [1:0] fwd
);

  // Priority compare of the source register against the MEM and WB writers
  always_comb begin
    fwd = FWD_RF;
    if (we_mem && (wa_mem != 5'd0) && (wa_mem == src)) begin
      fwd = FWD_MEM;
    end else if (we_wb && (wa_wb != 5'd0) && (wa_wb == src)) begin
      fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use stall,
// taken-branch flush, multi-cycle op stall FSM and saturating
// stall/flush performance counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEFAULT
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic [4:0]  rsD,
  input  logic [4:0]  rtD,
  input  logic [4:0]  rsE,
  input  logic [4:0]  rtE,
  input  logic        RFWEE,
  input  logic        MtoRFSelE,
  input  logic        BranchE,
  input  logic        BrTakenE,
  input  logic        MulStartE,
  input  logic        RFWEM,
  input  logic        RFWEW,
  input  logic [4:0]  RFWAM,
  input  logic [4:0]  RFWAW,
  input  logic        cnt_clr,
  output logic        StallF,
  output logic        StallD,
  output logic        FlushD,
  output logic        FlushE,
  output logic        HoldM,
  output logic [1:0]  FwdAE,
  output logic [1:0]  FwdBE,
  output logic        MulBusy,
  output logic [15:0] StallCnt,
  output logic [15:0] FlushCnt
);

  // The op occupies EX for MUL_LAT cycles; the start cycle itself runs,
  // so MULBUSY lasts MUL_LAT-1 cycles (mcnt counts MUL_LAT-2 down to 0).
  localparam logic [3:0] MCNT_LOAD = 4'(MUL_LAT - 2);

  state_t      state_reg, state_next;
  logic [3:0]  mcnt_reg, mcnt_next;
  logic [15:0] stall_cnt_reg, flush_cnt_reg;
  logic        lu, tb;

  // One forwarding comparator per ALU operand
  fwd_sel u_fwd_a (
    .src    (rsE),
    .we_mem (RFWEM),
    .wa_mem (RFWAM),
    .we_wb  (RFWEW),
    .wa_wb  (RFWAW),
    .fwd    (FwdAE)
  );

  fwd_sel u_fwd_b (
    .src    (rtE),
    .we_mem (RFWEM),
    .wa_mem (RFWAM),
    .we_wb  (RFWEW),
    .wa_wb  (RFWAW),
    .fwd    (FwdBE)
  );

  // Hazard detection terms from the current EX/ID contents
  assign lu = RFWEE & MtoRFSelE & (rtE != 5'd0) & ((rtE == rsD) | (rtE == rtD));
  assign tb = BranchE & BrTakenE;

  // State and multi-cycle counter registers
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_reg <= RUN;
      mcnt_reg  <= 4'd0;
    end else begin
      state_reg <= state_next;
      mcnt_reg  <= mcnt_next;
    end
  end

  // Next-state logic and stall/flush/hold outputs (no registered latency)
  always_comb begin
    state_next = state_reg;
    mcnt_next  = mcnt_reg;
    StallF     = 1'b0;
    StallD     = 1'b0;
    FlushD     = 1'b0;
    FlushE     = 1'b0;
    HoldM      = 1'b0;
    MulBusy    = 1'b0;
    case (state_reg)
      RUN: begin
        if (MulStartE) begin
          state_next = MULBUSY;
          mcnt_next  = MCNT_LOAD;
        end
        // A taken branch squashes the stalled instruction anyway, so it wins
        if (tb) begin
          FlushD = 1'b1;
          FlushE = 1'b1;
        end else if (lu) begin
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
        end
      end
      MULBUSY: begin
        StallF  = 1'b1;
        StallD  = 1'b1;
        FlushE  = 1'b1;
        HoldM   = 1'b1;
        MulBusy = 1'b1;
        if (mcnt_reg == 4'd0) begin
          state_next = RUN;
        end else begin
          mcnt_next = mcnt_reg - 4'd1;
        end
      end
      default: begin
        state_next = RUN;
        mcnt_next  = 4'd0;
      end
    endcase
  end

  // Saturating performance counters; clear beats increment
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      stall_cnt_reg <= 16'd0;
      flush_cnt_reg <= 16'd0;
    end else if (cnt_clr) begin
      stall_cnt_reg <= 16'd0;
      flush_cnt_reg <= 16'd0;
    end else begin
      if (StallD && (stall_cnt_reg != 16'hFFFF)) begin
        stall_cnt_reg <= stall_cnt_reg + 16'd1;
      end
      if (tb && (state_reg == RUN) && (flush_cnt_reg != 16'hFFFF)) begin
        flush_cnt_reg <= flush_cnt_reg + 16'd1;
      end
    end
  end

  assign StallCnt = stall_cnt_reg;
  assign FlushCnt = flush_cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: a table of combinational vectors
// in RUN, then hand-written multi-cycle sequences.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        clr_n;
  logic [4:0]  rsD, rtD, rsE, rtE, RFWAM, RFWAW;
  logic        RFWEE, MtoRFSelE, BranchE, BrTakenE, MulStartE, RFWEM, RFWEW, cnt_clr;
  logic        StallF, StallD, FlushD, FlushE, HoldM, MulBusy;
  logic [1:0]  FwdAE, FwdBE;
  logic [15:0] StallCnt, FlushCnt;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MUL_LAT(4)) dut (
    .clk(clk), .clr_n(clr_n),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .RFWEE(RFWEE), .MtoRFSelE(MtoRFSelE),
    .BranchE(BranchE), .BrTakenE(BrTakenE), .MulStartE(MulStartE),
    .RFWEM(RFWEM), .RFWEW(RFWEW), .RFWAM(RFWAM), .RFWAW(RFWAW),
    .cnt_clr(cnt_clr),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .HoldM(HoldM), .FwdAE(FwdAE), .FwdBE(FwdBE), .MulBusy(MulBusy),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  typedef struct {
    logic [4:0] rsD, rtD, rsE, rtE;
    logic       we_e, ld_e, br_e, tk_e;
    logic       we_m;
    logic [4:0] wa_m;
    logic       we_w;
    logic [4:0] wa_w;
    logic [1:0] exp_fa, exp_fb;
    logic [4:0] exp_ctl;  // {StallF, StallD, FlushD, FlushE, HoldM}
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rsD = 0; rtD = 0; rsE = 0; rtE = 0; RFWAM = 0; RFWAW = 0;
    RFWEE = 0; MtoRFSelE = 0; BranchE = 0; BrTakenE = 0; MulStartE = 0;
    RFWEM = 0; RFWEW = 0; cnt_clr = 0;
  endtask

  task automatic clear_counters();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
  endtask

  initial begin
    //           rsD rtD rsE rtE we ld br tk weM waM weW waW  fa     fb     ctl
    vecs[0]  = '{0,  0,  0,  0,  0, 0, 0, 0, 0,  0,  0,  0,  2'b00, 2'b00, 5'b00000};
    vecs[1]  = '{0,  0,  3,  0,  0, 0, 0, 0, 1,  3,  1,  3,  2'b10, 2'b00, 5'b00000};
    vecs[2]  = '{0,  0,  3,  0,  0, 0, 0, 0, 1,  0,  1,  3,  2'b01, 2'b00, 5'b00000};
    vecs[3]  = '{0,  0,  0,  0,  0, 0, 0, 0, 1,  3,  1,  3,  2'b00, 2'b00, 5'b00000};
    vecs[4]  = '{0,  0,  7,  7,  0, 0, 0, 0, 0,  7,  1,  7,  2'b01, 2'b01, 5'b00000};
    vecs[5]  = '{0,  0,  7,  7,  0, 0, 0, 0, 1,  7,  0,  7,  2'b10, 2'b10, 5'b00000};
    vecs[6]  = '{5,  0,  0,  5,  1, 1, 0, 0, 0,  0,  0,  0,  2'b00, 2'b00, 5'b11010};
    vecs[7]  = '{0,  5,  0,  5,  1, 1, 0, 0, 0,  0,  0,  0,  2'b00, 2'b00, 5'b11010};
    vecs[8]  = '{0,  0,  0,  0,  1, 1, 0, 0, 0,  0,  0,  0,  2'b00, 2'b00, 5'b00000};
    vecs[9]  = '{5,  0,  0,  5,  1, 0, 0, 0, 0,  0,  0,  0,  2'b00, 2'b00, 5'b00000};
    vecs[10] = '{0,  0,  0,  0,  0, 0, 1, 1, 0,  0,  0,  0,  2'b00, 2'b00, 5'b00110};
    vecs[11] = '{0,  0,  0,  0,  0, 0, 1, 0, 0,  0,  0,  0,  2'b00, 2'b00, 5'b00000};
    vecs[12] = '{5,  0,  0,  5,  1, 1, 1, 1, 0,  0,  0,  0,  2'b00, 2'b00, 5'b00110};

    // Reset state
    idle_inputs();
    clr_n = 1'b0;
    #2;
    check("rst_mulbusy", MulBusy, 0);
    check("rst_holdm", HoldM, 0);
    check("rst_stallcnt", StallCnt, 0);
    check("rst_flushcnt", FlushCnt, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    clr_n = 1'b1;
    tick();

    // Combinational vectors in RUN
    for (int i = 0; i < 13; i++) begin
      rsD = vecs[i].rsD; rtD = vecs[i].rtD; rsE = vecs[i].rsE; rtE = vecs[i].rtE;
      RFWEE = vecs[i].we_e; MtoRFSelE = vecs[i].ld_e;
      BranchE = vecs[i].br_e; BrTakenE = vecs[i].tk_e;
      RFWEM = vecs[i].we_m; RFWAM = vecs[i].wa_m;
      RFWEW = vecs[i].we_w; RFWAW = vecs[i].wa_w;
      @(negedge clk);
      check($sformatf("vec%0d_fwda", i), FwdAE, vecs[i].exp_fa);
      check($sformatf("vec%0d_fwdb", i), FwdBE, vecs[i].exp_fb);
      check($sformatf("vec%0d_ctl", i), {StallF, StallD, FlushD, FlushE, HoldM}, vecs[i].exp_ctl);
      tick();
    end

    // Load-use stall for one cycle, bubble clears it
    idle_inputs();
    clear_counters();
    RFWEE = 1; MtoRFSelE = 1; rtE = 5; rsD = 5;
    @(negedge clk);
    check("lu_stall", {StallF, StallD, FlushE}, 3'b111);
    tick();
    idle_inputs();
    @(negedge clk);
    check("lu_after", {StallF, StallD, FlushE}, 3'b000);
    check("lu_stallcnt", StallCnt, 1);

    // Load-use and taken branch together: branch wins
    clear_counters();
    RFWEE = 1; MtoRFSelE = 1; rtE = 5; rsD = 5; BranchE = 1; BrTakenE = 1;
    @(negedge clk);
    check("lutb_ctl", {StallD, FlushD, FlushE}, 3'b011);
    tick();
    idle_inputs();
    @(negedge clk);
    check("lutb_flushcnt", FlushCnt, 1);
    check("lutb_stallcnt", StallCnt, 0);

    // Multi-cycle op: 3 busy cycles; a taken branch held throughout is
    // ignored while busy and acted on in the first RUN cycle
    clear_counters();
    MulStartE = 1;
    @(negedge clk);
    check("mul_start_busy", MulBusy, 0);
    check("mul_start_stall", StallD, 0);
    tick();
    MulStartE = 0; BranchE = 1; BrTakenE = 1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("mul_c%0d_busy", k), {MulBusy, HoldM, StallF, StallD, FlushE},
            (k <= 3) ? 5'b11111 : 5'b00001);
      check($sformatf("mul_c%0d_flushd", k), FlushD, (k == 4) ? 1 : 0);
      tick();
    end
    idle_inputs();
    @(negedge clk);
    check("mul_stallcnt", StallCnt, 3);
    check("mul_flushcnt", FlushCnt, 1);

    // Reset in the second busy cycle aborts the op
    tick();
    MulStartE = 1;
    tick();
    MulStartE = 0;
    tick();
    @(negedge clk);
    check("abort_busy_before", MulBusy, 1);
    clr_n = 1'b0;
    #1;
    check("abort_busy", MulBusy, 0);
    check("abort_holdm", HoldM, 0);
    check("abort_stallcnt", StallCnt, 0);
    check("abort_flushcnt", FlushCnt, 0);
    @(negedge clk);
    clr_n = 1'b1;
    tick();
    @(negedge clk);
    check("abort_run_busy", MulBusy, 0);
    check("abort_run_stall", StallD, 0);

    // Counter saturation under a permanent load-use stall, then clear
    tick();
    RFWEE = 1; MtoRFSelE = 1; rtE = 5; rsD = 5;
    repeat (70000) @(posedge clk);
    @(negedge clk);
    check("sat_stallcnt", StallCnt, 16'hFFFF);
    cnt_clr = 1'b1;
    tick();
    check("clr_stallcnt", StallCnt, 0);
    cnt_clr = 1'b0;
    tick();
    check("clr_then_inc", StallCnt, 1);
    idle_inputs();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
